// File: rtl/drawline.sv
// Vertical span rasteriser: walks one column of a 4-column draw block from y_start to y_end,
// depth-tests each pixel and writes RGB565 colour and depth using saturating attribute steps.
module drawline (
    input  logic         clk,
    input  logic         rst,
    input  logic [160:0] span_data,
    input  logic         span_start,
    output logic         span_done,
    output logic [9:0]   pix_addr,
    output logic [15:0]  pix_data,
    output logic         pix_we,
    output logic [9:0]   depth_addr,
    input  logic [15:0]  depth_rddata,
    output logic [15:0]  depth_wrdata,
    output logic         depth_we
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        TEST = 2'd2
    } state_t;

    state_t      state_r;
    logic [7:0]  cur_y_r;
    logic [7:0]  y_end_r;
    logic        y_up_r;
    logic [1:0]  x_r;
    logic [23:0] cur_z_r;
    logic [24:0] nz_r;
    logic [13:0] cur_r_r;
    logic [14:0] nr_r;
    logic [14:0] cur_g_r;
    logic [15:0] ng_r;
    logic [13:0] cur_b_r;
    logic [14:0] nb_r;

    logic [23:0] sum_z_s;
    logic [23:0] sum_r_s;
    logic [23:0] sum_g_s;
    logic [23:0] sum_b_s;
    logic [15:0] zd_s;
    logic        hit_s;
    logic        unused_s;

    // Adds a sign-extended step to a w-bit unsigned field. Bit w of the wide sum is the carry
    // (positive step) or the borrow (negative step), so it alone decides clamping.
    function automatic logic [23:0] sat_add(input logic [23:0] a, input logic [24:0] d,
                                            input logic [4:0] w);
        logic [24:0] sum_v;
        logic [24:0] mask_v;
        mask_v = (25'd1 << w) - 25'd1;
        sum_v  = {1'b0, a} + d;
        if (sum_v[w]) begin
            sat_add = d[24] ? 24'd0 : mask_v[23:0];
        end else begin
            sat_add = sum_v[23:0] & mask_v[23:0];
        end
    endfunction

    // Next attribute values and the per-pixel depth test.
    always_comb begin
        sum_z_s = sat_add(cur_z_r, nz_r, 5'd24);
        sum_r_s = sat_add({10'd0, cur_r_r}, {{10{nr_r[14]}}, nr_r}, 5'd14);
        sum_g_s = sat_add({9'd0, cur_g_r}, {{9{ng_r[15]}}, ng_r}, 5'd15);
        sum_b_s = sat_add({10'd0, cur_b_r}, {{10{nb_r[14]}}, nb_r}, 5'd14);
        zd_s    = {1'b0, cur_z_r[23:9]};
        hit_s   = (state_r == TEST) && (zd_s < depth_rddata) && !rst;
    end

    assign unused_s     = ^{span_data[160:156], sum_r_s[23:14], sum_g_s[23:15], sum_b_s[23:14]};
    assign span_done    = (state_r == IDLE);
    assign depth_addr   = {x_r, cur_y_r};
    assign pix_addr     = {x_r, cur_y_r};
    assign pix_data     = {cur_r_r[13:9], cur_g_r[14:9], cur_b_r[13:9]};
    assign depth_wrdata = zd_s;
    assign pix_we       = hit_s;
    assign depth_we     = hit_s;

    // Span sequencer: latch in IDLE, then alternate READ/TEST once per row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cur_y_r <= 8'd0;
            y_end_r <= 8'd0;
            y_up_r  <= 1'b0;
            x_r     <= 2'd0;
            cur_z_r <= 24'd0;
            nz_r    <= 25'd0;
            cur_r_r <= 14'd0;
            nr_r    <= 15'd0;
            cur_g_r <= 15'd0;
            ng_r    <= 16'd0;
            cur_b_r <= 14'd0;
            nb_r    <= 15'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (span_start) begin
                        cur_y_r <= span_data[155:148];
                        y_end_r <= span_data[147:140];
                        y_up_r  <= (span_data[155:148] < span_data[147:140]);
                        x_r     <= span_data[139:138];
                        cur_z_r <= span_data[137:114];
                        nz_r    <= span_data[113:89];
                        cur_r_r <= span_data[88:75];
                        nr_r    <= span_data[74:60];
                        cur_g_r <= span_data[59:45];
                        ng_r    <= span_data[44:29];
                        cur_b_r <= span_data[28:15];
                        nb_r    <= span_data[14:0];
                        state_r <= READ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    state_r <= TEST;
                end
                TEST: begin
                    if (cur_y_r == y_end_r) begin
                        state_r <= IDLE;
                    end else begin
                        cur_y_r <= y_up_r ? (cur_y_r + 8'd1) : (cur_y_r - 8'd1);
                        cur_z_r <= sum_z_s;
                        cur_r_r <= sum_r_s[13:0];
                        cur_g_r <= sum_g_s[14:0];
                        cur_b_r <= sum_b_s[13:0];
                        state_r <= READ;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_drawline.sv
// Self-checking bench for drawline: table of spans plus hand sequences, with a depth memory
// model and a scoreboard of expected colour/depth writes.
module tb_drawline;
    logic         clk = 1'b0;
    logic         rst;
    logic [160:0] span_data;
    logic         span_start;
    logic         span_done;
    logic [9:0]   pix_addr;
    logic [15:0]  pix_data;
    logic         pix_we;
    logic [9:0]   depth_addr;
    logic [15:0]  depth_rddata;
    logic [15:0]  depth_wrdata;
    logic         depth_we;

    always #5 clk = ~clk;

    drawline dut (
        .clk(clk), .rst(rst), .span_data(span_data), .span_start(span_start),
        .span_done(span_done), .pix_addr(pix_addr), .pix_data(pix_data), .pix_we(pix_we),
        .depth_addr(depth_addr), .depth_rddata(depth_rddata), .depth_wrdata(depth_wrdata),
        .depth_we(depth_we)
    );

    typedef struct {
        int y0; int y1; int x; int z; int nz; int r; int nr; int g; int ng; int b; int nb;
        int fill; int busy; int writes;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] pix;
        logic [15:0] zd;
    } wr_t;

    int          chk = 0;
    int          err = 0;
    int          wr_count = 0;
    wr_t         exp_q[$];
    logic [15:0] obs_pix[$];
    wr_t         mon_e;
    logic [15:0] mem [0:1023];
    logic        fill_en;
    logic [15:0] fill_val;
    vec_t        tbl[7];

    // Synchronous depth RAM: one-cycle read latency, bulk fill for test setup.
    always @(posedge clk) begin
        depth_rddata <= mem[depth_addr];
        if (fill_en) begin
            for (int i = 0; i < 1024; i++) mem[i] <= fill_val;
        end else if (depth_we) begin
            mem[depth_addr] <= depth_wrdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (pix_we || depth_we) begin
            wr_count++;
            obs_pix.push_back(pix_data);
            check("pix_we", {31'd0, pix_we}, 32'd1);
            check("depth_we", {31'd0, depth_we}, 32'd1);
            if (exp_q.size() == 0) begin
                chk++;
                err++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required none", pix_addr, pix_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("pix_addr", {22'd0, pix_addr}, {22'd0, mon_e.addr});
                check("depth_addr", {22'd0, depth_addr}, {22'd0, mon_e.addr});
                check("pix_data", {16'd0, pix_data}, {16'd0, mon_e.pix});
                check("depth_wrdata", {16'd0, depth_wrdata}, {16'd0, mon_e.zd});
            end
        end
    end

    function automatic int sat(input int v, input int mx);
        if (v < 0) return 0;
        else if (v > mx) return mx;
        else return v;
    endfunction

    function automatic logic [160:0] pack(input vec_t v);
        logic [160:0] d;
        d = '0;
        d[160:156] = 5'h15;
        d[155:148] = 8'(v.y0);
        d[147:140] = 8'(v.y1);
        d[139:138] = 2'(v.x);
        d[137:114] = 24'(v.z);
        d[113:89]  = 25'(v.nz);
        d[88:75]   = 14'(v.r);
        d[74:60]   = 15'(v.nr);
        d[59:45]   = 15'(v.g);
        d[44:29]   = 16'(v.ng);
        d[28:15]   = 14'(v.b);
        d[14:0]    = 15'(v.nb);
        return d;
    endfunction

    task automatic fill_mem(input int val);
        fill_val = 16'(val);
        fill_en  = 1'b1;
        tick();
        fill_en  = 1'b0;
    endtask

    // Fills depth, predicts writes, runs one span and checks row addresses and timing.
    task automatic run_span(input vec_t v, input bit hold);
        int          y, z, r, g, b, zd, busy, w0;
        logic [9:0]  addr_q[$];
        logic [9:0]  a;
        logic [191:0] junk;
        wr_t         w;
        fill_mem(v.fill);
        obs_pix.delete();
        y = v.y0; z = v.z; r = v.r; g = v.g; b = v.b;
        for (int k = 0; k < 256; k++) begin
            a = {2'(v.x), 8'(y)};
            addr_q.push_back(a);
            zd = z >> 9;
            if (zd < v.fill) begin
                w.addr = a;
                w.pix  = {5'(r >> 9), 6'(g >> 9), 5'(b >> 9)};
                w.zd   = 16'(zd);
                exp_q.push_back(w);
            end
            if (y == v.y1) break;
            y = (v.y0 < v.y1) ? y + 1 : y - 1;
            z = sat(z + v.nz, 32'hFFFFFF);
            r = sat(r + v.nr, 32'h3FFF);
            g = sat(g + v.ng, 32'h7FFF);
            b = sat(b + v.nb, 32'h3FFF);
        end
        w0 = wr_count;
        span_data  = pack(v);
        span_start = 1'b1;
        tick();
        span_start = hold;
        junk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        span_data = junk[160:0];
        busy = 0;
        while (!span_done && busy < 1000) begin
            if (busy % 2 == 0 && addr_q.size() > 0)
                check("read_addr", {22'd0, depth_addr}, {22'd0, addr_q.pop_front()});
            busy++;
            tick();
        end
        span_start = 1'b0;
        check("busy_cycles", busy, v.busy);
        check("write_count", wr_count - w0, v.writes);
        check("scoreboard_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        vec_t v;
        int   w0;
        int   exp_r[4];
        int   exp_g[2];
        rst = 1'b1; span_start = 1'b0; span_data = '0; fill_en = 1'b0; fill_val = 16'd0;
        tick();
        tick();
        check("rst_span_done", {31'd0, span_done}, 32'd1);
        check("rst_pix_we", {31'd0, pix_we}, 32'd0);
        check("rst_depth_we", {31'd0, depth_we}, 32'd0);
        check("rst_pix_addr", {22'd0, pix_addr}, 32'd0);
        check("rst_depth_addr", {22'd0, depth_addr}, 32'd0);
        check("rst_pix_data", {16'd0, pix_data}, 32'd0);
        check("rst_depth_wrdata", {16'd0, depth_wrdata}, 32'd0);
        rst = 1'b0;
        tick();

        tbl[0] = '{y0:10, y1:10, x:2, z:32'hA00, nz:0, r:0, nr:0, g:0, ng:0, b:0, nb:0,
                   fill:32'hFFFF, busy:2, writes:1};
        tbl[1] = '{y0:6, y1:3, x:3, z:32'h1000, nz:32'h200, r:32'h1000, nr:0, g:0, ng:0, b:0, nb:0,
                   fill:0, busy:8, writes:0};
        tbl[2] = '{y0:50, y1:45, x:0, z:32'hF000, nz:-32'sh2000, r:32'h200, nr:32'h300, g:32'h7FFF, ng:1,
                   b:32'h100, nb:-32'sh50, fill:32'h70, busy:12, writes:5};
        tbl[3] = '{y0:253, y1:255, x:3, z:0, nz:0, r:32'h3FFF, nr:-32'sh1000, g:0, ng:32'h1234, b:0, nb:32'h800,
                   fill:32'hFFFF, busy:6, writes:3};
        tbl[4] = '{y0:1, y1:0, x:1, z:32'h200, nz:32'h200, r:0, nr:0, g:0, ng:0, b:32'h3FFF, nb:32'h10,
                   fill:32'h2, busy:4, writes:1};
        tbl[5] = '{y0:200, y1:202, x:1, z:32'hFFF000, nz:32'h100000, r:0, nr:0, g:0, ng:0, b:0, nb:0,
                   fill:32'hFFFF, busy:6, writes:3};
        tbl[6] = '{y0:200, y1:202, x:2, z:32'hFFF000, nz:32'h100000, r:0, nr:0, g:0, ng:0, b:0, nb:0,
                   fill:32'h7FFF, busy:6, writes:1};

        // Reset wins over a simultaneous start.
        rst = 1'b1; span_start = 1'b1; span_data = pack(tbl[0]);
        tick();
        rst = 1'b0; span_start = 1'b0;
        check("rst_vs_start_done", {31'd0, span_done}, 32'd1);
        tick();
        check("rst_vs_start_still_idle", {31'd0, span_done}, 32'd1);

        for (int i = 0; i < 7; i++) run_span(tbl[i], 1'b0);

        // Upward span: r5 field counts 0..3.
        v = '{y0:3, y1:6, x:1, z:32'h1000, nz:0, r:0, nr:32'h200, g:0, ng:0, b:0, nb:0,
              fill:32'hFFFF, busy:8, writes:4};
        run_span(v, 1'b0);
        exp_r = '{0, 1, 2, 3};
        check("up_obs_count", obs_pix.size(), 4);
        for (int i = 0; i < 4 && i < obs_pix.size(); i++)
            check("up_r_field", {27'd0, obs_pix[i][15:11]}, exp_r[i]);

        // Positive saturation of r.
        v = '{y0:0, y1:2, x:0, z:0, nz:0, r:32'h3E00, nr:32'h400, g:0, ng:0, b:0, nb:0,
              fill:32'hFFFF, busy:6, writes:3};
        run_span(v, 1'b0);
        check("rsat_obs_count", obs_pix.size(), 3);
        for (int i = 0; i < obs_pix.size(); i++)
            check("rsat_r_field", {27'd0, obs_pix[i][15:11]}, 32'd31);

        // Negative saturation of g.
        v = '{y0:20, y1:21, x:2, z:0, nz:0, r:0, nr:0, g:32'h200, ng:-32'sh400, b:0, nb:0,
              fill:32'hFFFF, busy:4, writes:2};
        run_span(v, 1'b0);
        exp_g = '{1, 0};
        check("gneg_obs_count", obs_pix.size(), 2);
        for (int i = 0; i < 2 && i < obs_pix.size(); i++)
            check("gneg_g_field", {26'd0, obs_pix[i][10:5]}, exp_g[i]);

        // span_start held high for the whole span: exactly one span.
        w0 = wr_count;
        run_span(tbl[3], 1'b1);
        repeat (4) tick();
        check("hold_idle", {31'd0, span_done}, 32'd1);
        check("hold_single_span", wr_count - w0, 32'd3);

        // Reset during TEST discards the span with no write.
        fill_mem(32'hFFFF);
        w0 = wr_count;
        v = '{y0:40, y1:43, x:2, z:0, nz:0, r:32'h3FFF, nr:0, g:0, ng:0, b:0, nb:0,
              fill:32'hFFFF, busy:8, writes:4};
        span_data = pack(v);
        span_start = 1'b1;
        tick();
        span_start = 1'b0;
        check("abort_busy", {31'd0, span_done}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_done", {31'd0, span_done}, 32'd1);
        check("abort_pix_addr", {22'd0, pix_addr}, 32'd0);
        check("abort_pix_data", {16'd0, pix_data}, 32'd0);
        repeat (6) tick();
        check("abort_no_writes", wr_count - w0, 32'd0);
        check("abort_still_idle", {31'd0, span_done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule

// File: doc/drawline.md
DRAWLINE -- requirements
Module: drawline

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 span_data  in  161  span descriptor, MSB first: reserved[160:156], y_start[155:148] (8.0), y_end[147:140] (8.0), x[139:138] (column within 4-column draw block), z[137:114] (15.9), nz[113:89] (s.15.9), r[88:75] (5.9), nr[74:60] (s.5.9), g[59:45] (6.9), ng[44:29] (s.6.9), b[28:15] (5.9), nb[14:0] (s.5.9).
REQ-005 span_start  in  1  one-cycle request; span_data is valid in the same cycle.
REQ-006 span_done  out  1  level; 1 = idle and able to accept a span.
REQ-007 pix_addr  out  10  colour buffer address {x, y}.
REQ-008 pix_data  out  16  RGB565 pixel.
REQ-009 pix_we  out  1  colour write strobe.
REQ-010 depth_addr  out  10  depth buffer address {x, y}; read and write share this address.
REQ-011 depth_rddata  in  16  depth read data; valid one cycle after depth_addr is presented.
REQ-012 depth_wrdata  out  16  depth write data.
REQ-013 depth_we  out  1  depth write strobe.

Function
REQ-014 The FSM SHALL have the states IDLE, READ and TEST; span_done SHALL be 1 exactly when the state is IDLE.
REQ-015 In IDLE with span_start=1, the block SHALL latch all span fields, set cur_y=y_start, and enter READ; span_done SHALL be 0 from the next cycle.
REQ-016 span_start SHALL be ignored in READ and TEST.
REQ-017 In READ, depth_addr SHALL equal {x, cur_y}; the next state is always TEST.
REQ-018 In TEST, zd={1'b0, cur_z[23:9]}; if zd < depth_rddata (unsigned), pix_we and depth_we SHALL be 1 for that cycle with pix_addr=depth_addr={x, cur_y}, depth_wrdata=zd, and pix_data={cur_r[13:9], cur_g[14:9], cur_b[13:9]}.
REQ-019 pix_we and depth_we SHALL be 0 in every state other than TEST.
REQ-020 In TEST, if cur_y==y_end the next state SHALL be IDLE; otherwise cur_y SHALL step by +1 when y_start<y_end and by -1 when y_start>y_end, each attribute SHALL add its n step, and the next state SHALL be READ.
REQ-021 The block SHALL process every row from y_start to y_end inclusive; y_start==y_end is a one-row span.
REQ-022 A span SHALL occupy exactly 2*(|y_end-y_start|+1) cycles from the first READ to the return to IDLE.
REQ-023 Attribute accumulation SHALL saturate: if a sum overflows negative the result is 0; if it overflows past the field maximum the result is all-ones (z 24'hFFFFFF, r/b 14'h3FFF, g 15'h7FFF).
REQ-024 Saturation SHALL be detected from the carry into the bit above the field and the sign of the step; there SHALL be no wrap-around.
REQ-025 The reserved bits of span_data SHALL be ignored.
REQ-026 Outputs SHALL be driven from the state and the latched registers only; span_data may change after the start cycle without effect.

Reset
REQ-027 On rst, the state SHALL become IDLE and span_done SHALL be 1 in the following cycle.
REQ-028 On rst, pix_we and depth_we SHALL be 0.
REQ-029 On rst, pix_addr, pix_data, depth_addr and depth_wrdata SHALL be 0.
REQ-030 Reset SHALL take priority over span_start arriving in the same cycle.
REQ-031 A span interrupted by reset SHALL be discarded with no further writes.

Verification
REQ-032 Single row: y_start=y_end=10, x=2, z=0x000A00 (zd=5), depth_rddata=0xFFFF -> one write at addr 0x20A with depth_wrdata=5; span_done is 0 for 2 cycles.
REQ-033 Upward span: y 3->6, r=0, nr=+0x200 -> writes at y=3,4,5,6 with r5 field 0,1,2,3; busy 8 cycles.
REQ-034 Downward span: y 6->3, depth_rddata=0 -> no pix_we or depth_we pulses, addresses walk y=6,5,4,3, then span_done=1.
REQ-035 Saturation: r=0x3E00, nr=+0x0400 over 3 rows -> r5 field 31, 31, 31 (clamped to 0x3FFF); negative case g=0x0200, ng=-0x0400 -> g field 1, then 0.
REQ-036 Control edges: span_start held high while busy -> exactly one span processed; rst asserted in a TEST cycle -> no write after reset, span_done=1 on the next cycle.
